// File: rtl/alpha_rd_sched.sv
// alpha_rd_sched: walks the SCAN tree from top_layer down to bot_layer, issuing alpha
// storage reads per stage and the matching writes PE_LAT+1 cycles later.
module alpha_rd_sched #(
  parameter int PE_LAT = 2,
  parameter int MAX_L  = 10,
  parameter int PW_LOG = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] top_layer,
  input  logic [4:0] bot_layer,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       r_en,
  output logic [4:0] layer_r,
  output logic [4:0] cntb,
  output logic       w_en,
  output logic [4:0] layer_w,
  output logic [5:0] cnta,
  output logic       pe_valid,
  output logic       pe_last
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  function automatic logic [5:0] chunks(input logic [4:0] l);
    return (l >= 5'(PW_LOG + 1)) ? 6'd1 << (l - 5'(PW_LOG + 1)) : 6'd1;
  endfunction
  state_t state_q, state_d;
  logic [4:0] cur_q, cur_d, bot_q, bot_d, layer_r_q, layer_r_d, cntb_q, cntb_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, r_en_q, r_en_d;
  logic pe_valid_q, pe_valid_d, pe_last_q, pe_last_d;
  logic [PE_LAT:0] sr_v_q, sr_v_d, sr_last_q, sr_last_d;
  logic [PE_LAT:0][5:0] sr_idx_q, sr_idx_d;
  logic [PE_LAT:0][4:0] sr_lay_q, sr_lay_d;
  logic rd_last, w_last, illegal;
  assign rd_last = r_en_q && ({1'b0, cntb_q} == chunks(layer_r_q) - 6'd1);
  assign w_last  = sr_v_q[PE_LAT] && sr_last_q[PE_LAT];
  assign illegal = top_layer > 5'(MAX_L) || top_layer < 5'd2 || bot_layer == 5'd0 ||
                   bot_layer >= top_layer;
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    bot_d      = bot_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    r_en_d     = 1'b0;
    layer_r_d  = 5'd0;
    cntb_d     = 5'd0;
    pe_valid_d = r_en_q;
    pe_last_d  = rd_last;
    case (state_q)
      S_IDLE: if (start) begin
        err_d = illegal;
        if (!illegal) begin
          state_d   = S_READ;
          cur_d     = top_layer;
          bot_d     = bot_layer;
          busy_d    = 1'b1;
          r_en_d    = 1'b1;
          layer_r_d = top_layer;
        end
      end
      S_READ: begin
        state_d   = rd_last ? S_DRAIN : S_READ;
        r_en_d    = !rd_last;
        layer_r_d = rd_last ? 5'd0 : cur_q;
        cntb_d    = rd_last ? 5'd0 : cntb_q + 5'd1;
      end
      S_DRAIN: if (w_last) begin
        if (cur_q - 5'd1 == bot_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = S_READ;
          cur_d     = cur_q - 5'd1;
          r_en_d    = 1'b1;
          layer_r_d = cur_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sr_v_d       = sr_v_q;
    sr_last_d    = sr_last_q;
    sr_idx_d     = sr_idx_q;
    sr_lay_d     = sr_lay_q;
    sr_v_d[0]    = r_en_q;
    sr_last_d[0] = rd_last;
    sr_idx_d[0]  = {1'b0, cntb_q};
    sr_lay_d[0]  = r_en_q ? layer_r_q - 5'd1 : 5'd0;
    for (int i = 1; i <= PE_LAT; i++) begin
      sr_v_d[i]    = sr_v_q[i-1];
      sr_last_d[i] = sr_last_q[i-1];
      sr_idx_d[i]  = sr_idx_q[i-1];
      sr_lay_d[i]  = sr_lay_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      bot_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      r_en_q     <= 1'b0;
      layer_r_q  <= '0;
      cntb_q     <= '0;
      pe_valid_q <= 1'b0;
      pe_last_q  <= 1'b0;
      sr_v_q     <= '0;
      sr_last_q  <= '0;
      sr_idx_q   <= '0;
      sr_lay_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      bot_q      <= bot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      r_en_q     <= r_en_d;
      layer_r_q  <= layer_r_d;
      cntb_q     <= cntb_d;
      pe_valid_q <= pe_valid_d;
      pe_last_q  <= pe_last_d;
      sr_v_q     <= sr_v_d;
      sr_last_q  <= sr_last_d;
      sr_idx_q   <= sr_idx_d;
      sr_lay_q   <= sr_lay_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign r_en     = r_en_q;
  assign layer_r  = layer_r_q;
  assign cntb     = cntb_q;
  assign w_en     = sr_v_q[PE_LAT];
  assign layer_w  = sr_lay_q[PE_LAT];
  assign cnta     = sr_idx_q[PE_LAT];
  assign pe_valid = pe_valid_q;
  assign pe_last  = pe_last_q;
endmodule

// File: tb/tb_alpha_rd_sched.sv
// tb_alpha_rd_sched: per-cycle comparison of two builds (PE_LAT=2 and PE_LAT=0)
// against a stage/chunk timeline model, plus hand-computed pins.
module tb_alpha_rd_sched;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       r_en;
    logic [4:0] layer_r;
    logic [4:0] cntb;
    logic       w_en;
    logic [4:0] layer_w;
    logic [5:0] cnta;
    logic       pe_valid;
    logic       pe_last;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [4:0] top0 = '0, bot0 = '0, top1 = '0, bot1 = '0;
  logic busy0, done0, err0, r_en0, w_en0, pv0, pl0;
  logic busy1, done1, err1, r_en1, w_en1, pv1, pl1;
  logic [4:0] lr0, cb0, lw0, lr1, cb1, lw1;
  logic [5:0] ca0, ca1;
  exp_t e [2][0:1023];
  int cyc = 0, checks = 0, failures = 0;
  bit cmp_on = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alpha_rd_sched #(.PE_LAT(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .top_layer(top0), .bot_layer(bot0),
    .busy(busy0), .done(done0), .err(err0), .r_en(r_en0), .layer_r(lr0), .cntb(cb0),
    .w_en(w_en0), .layer_w(lw0), .cnta(ca0), .pe_valid(pv0), .pe_last(pl0));
  alpha_rd_sched #(.PE_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .top_layer(top1), .bot_layer(bot1),
    .busy(busy1), .done(done1), .err(err1), .r_en(r_en1), .layer_r(lr1), .cntb(cb1),
    .w_en(w_en1), .layer_w(lw1), .cnta(ca1), .pe_valid(pv1), .pe_last(pl1));
  always @(negedge clk) if (cmp_on) begin
    exp_t g0, g1;
    g0 = exp_t'({busy0, done0, err0, r_en0, lr0, cb0, w_en0, lw0, ca0, pv0, pl0});
    g1 = exp_t'({busy1, done1, err1, r_en1, lr1, cb1, w_en1, lw1, ca1, pv1, pl1});
    checks += 2;
    if (g0 !== e[0][cyc]) begin
      failures++;
      $display("FAIL lat2_cycle cyc=%0d got=%h exp=%h", cyc, g0, e[0][cyc]);
    end
    if (g1 !== e[1][cyc]) begin
      failures++;
      $display("FAIL lat0_cycle cyc=%0d got=%h exp=%h", cyc, g1, e[1][cyc]);
    end
  end
  task automatic pin(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  // Timeline: each stage reads chunks(l) cycles, then the next stage starts the cycle
  // after its last write (lat+1 cycles after the last read).
  task automatic plan(input int w, input int b, input int top, input int bot, input int lat);
    int t, n;
    if (top > 10 || top < 2 || bot == 0 || bot >= top) e[w][b+1].err = 1'b1;
    else begin
      t = 1;
      for (int l = top; l > bot; l--) begin
        n = (l >= 6) ? (1 << (l - 6)) : 1;
        for (int c = 0; c < n; c++) begin
          e[w][b+t+c].r_en = 1'b1;
          e[w][b+t+c].layer_r = 5'(l);
          e[w][b+t+c].cntb = 5'(c);
          e[w][b+t+c+1].pe_valid = 1'b1;
          e[w][b+t+c+1].pe_last = (c == n - 1);
          e[w][b+t+c+lat+1].w_en = 1'b1;
          e[w][b+t+c+lat+1].layer_w = 5'(l - 1);
          e[w][b+t+c+lat+1].cnta = 6'(c);
        end
        t += n + lat + 1;
      end
      e[w][b+t].done = 1'b1;
      for (int k = 1; k < t; k++) e[w][b+k].busy = 1'b1;
    end
  endtask
  task automatic go(input int w, input int top, input int bot);
    if (w == 0) begin top0 = 5'(top); bot0 = 5'(bot); start0 = 1'b1; end
    else begin top1 = 5'(top); bot1 = 5'(bot); start1 = 1'b1; end
    plan(w, cyc, top, bot, w == 0 ? 2 : 0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask
  task automatic upto(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    int b;
    for (int i = 0; i < 1024; i++) begin e[0][i] = '0; e[1][i] = '0; end
    @(negedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    b = cyc;
    go(0, 10, 8);
    pin("model_t1_done", int'(e[0][b+31].done), 1);
    pin("model_t1_lastw", int'(e[0][b+19].cnta), 15);
    pin("model_t1_stage2", int'(e[0][b+20].layer_r), 9);
    upto(b + 4);
    pin("t1_first_w", int'({w_en0, lw0, ca0}), (1 << 11) | (9 << 6));
    upto(b + 5);
    start0 = 1'b1; top0 = 5'd3; bot0 = 5'd1;
    @(negedge clk);
    start0 = 1'b0;
    upto(b + 20);
    pin("t1_r_l9", int'({r_en0, lr0, cb0}), (1 << 10) | (9 << 5));
    upto(b + 31);
    pin("t1_done", int'({done0, busy0}), 2);
    upto(b + 34);
    b = cyc;
    go(0, 3, 1);
    upto(b + 4);
    pin("t2_w_l2", int'({w_en0, lw0}), (1 << 5) | 2);
    upto(b + 9);
    pin("t2_done", int'(done0), 1);
    upto(b + 12);
    b = cyc;
    go(0, 5, 5);
    pin("t3_err_eq", int'({err0, busy0}), 2);
    upto(b + 4);
    b = cyc;
    go(0, 11, 3);
    pin("t3_err_top11", int'({err0, busy0}), 2);
    upto(b + 4);
    go(0, 4, 0);
    upto(cyc + 3);
    b = cyc;
    go(0, 10, 8);
    upto(b + 10);
    rst = 1'b0;
    for (int i = cyc + 1; i < 1024; i++) begin e[0][i] = '0; e[1][i] = '0; end
    @(negedge clk);
    rst = 1'b1;
    pin("t4_rst_clear", int'({busy0, r_en0, w_en0, pv0, cb0}), 0);
    upto(b + 40);
    b = cyc;
    go(0, 10, 8);
    upto(b + 31);
    pin("t4_rerun_done", int'(done0), 1);
    upto(b + 34);
    b = cyc;
    go(1, 7, 6);
    upto(b + 2);
    pin("t6_w0", int'({w_en1, lw1, ca1}), (1 << 11) | (6 << 6));
    upto(b + 4);
    pin("t6_done", int'(done1), 1);
    upto(b + 7);
    b = cyc;
    go(1, 3, 1);
    upto(b + 10);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
